// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit framer.
// SYNC patterns are sent LSB-first by the serializer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_LOAD,
    SYNC_WAIT,
    DATA_LOAD,
    DATA_WAIT,
    FLUSH,
    EOP_SE0,
    EOP_J
  } tx_framer_state_t;

  localparam logic [7:0] SYNC_FILL = 8'h00;
  localparam logic [7:0] SYNC_LAST = 8'h80;

  // Last SYNC byte carries the single 1 that ends the pattern.
  function automatic logic [7:0] sync_byte(
    input int idx,
    input int n
  );
    return (idx + 1 >= n) ? SYNC_LAST : SYNC_FILL;
  endfunction

endpackage

// File: rtl/usb_tx_framer_if.sv
// Byte stream into the framer and the framer's serializer port.
// slave = framer side, master = source/serializer side.
interface usb_tx_framer_if;

  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic       piso_load;
  logic [7:0] piso_data;
  logic       piso_busy;
  logic       piso_done;

  modport master (
    output data_valid,
    output data_in,
    output piso_busy,
    output piso_done,
    input  data_ready,
    input  piso_load,
    input  piso_data
  );

  modport slave (
    input  data_valid,
    input  data_in,
    input  piso_busy,
    input  piso_done,
    output data_ready,
    output piso_load,
    output piso_data
  );

endinterface

// File: rtl/usb_eop_gen.sv
// End-of-packet line sequencer: EOP_SE0_BITS SE0 bit times, then one J.
// se0_end / j_end flag the bit_tick that closes each phase.
module usb_eop_gen
  import usb_tx_pkg::*;
#(
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_tick,
  output logic se0,
  output logic j,
  output logic se0_end,
  output logic j_end
);

  localparam int CW = $clog2(EOP_SE0_BITS + 1);

  logic [CW-1:0] cnt;

  assign se0_end = se0 && bit_tick &&
                   (cnt == CW'(EOP_SE0_BITS - 1));
  assign j_end   = j && bit_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      se0 <= 1'b0;
      j   <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      se0 <= 1'b1;
      j   <= 1'b0;
      cnt <= '0;
    end else if (se0_end) begin
      se0 <= 1'b0;
      j   <= 1'b1;
      cnt <= '0;
    end else if (se0 && bit_tick) begin
      cnt <= cnt + CW'(1);
    end else if (j_end) begin
      j <= 1'b0;
    end
  end

endmodule

// File: rtl/usb_tx_framer.sv
// USB packet framer: SYNC, payload and EOP sequencing onto a PISO.
// Serializer-facing outputs are registered from next-state decisions.
module usb_tx_framer
  import usb_tx_pkg::*;
#(
  parameter int SYNC_BYTES   = 1,
  parameter int MAX_LEN      = 64,
  parameter int EOP_SE0_BITS = 2,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             bit_tick,
  input  logic             stuffer_done,
  usb_tx_framer_if.slave   bus,
  output logic             line_se0,
  output logic             line_j,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_err
);

  localparam int SC_W = $clog2(SYNC_BYTES + 1);

  tx_framer_state_t state, state_nx;

  logic [SC_W-1:0]  sync_cnt, sync_cnt_nx;
  logic [LEN_W-1:0] rem, rem_nx;
  logic             load_q, load_nx;
  logic [7:0]       data_q, data_nx;
  logic             ready_q, ready_nx;
  logic             err_q, err_nx;
  logic             done_q, done_nx;

  logic start_ok, start_bad;
  logic hs, under;
  logic sync_more;
  logic load_sync;
  logic [SC_W-1:0] sync_idx;
  logic eop_start, se0_end, j_end;

  assign start_ok  = tx_start && (tx_len <= LEN_W'(MAX_LEN));
  assign start_bad = tx_start && (tx_len > LEN_W'(MAX_LEN));
  assign hs        = (state == DATA_LOAD) && ready_q &&
                     bus.data_valid;
  assign under     = (state == DATA_LOAD) && ready_q &&
                     !bus.data_valid;
  assign sync_more = sync_cnt < SC_W'(SYNC_BYTES);
  assign sync_idx  = (state == IDLE) ? '0 : sync_cnt;
  assign eop_start = (state == FLUSH) && stuffer_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sync_cnt <= '0;
      rem      <= '0;
      load_q   <= 1'b0;
      data_q   <= 8'h00;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      sync_cnt <= sync_cnt_nx;
      rem      <= rem_nx;
      load_q   <= load_nx;
      data_q   <= data_nx;
      ready_q  <= ready_nx;
      err_q    <= err_nx;
      done_q   <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start_ok) state_nx = SYNC_LOAD;
      SYNC_LOAD:
        if (load_q) state_nx = SYNC_WAIT;
      SYNC_WAIT:
        if (bus.piso_done) begin
          if (sync_more)     state_nx = SYNC_LOAD;
          else if (rem != 0) state_nx = DATA_LOAD;
          else               state_nx = FLUSH;
        end
      DATA_LOAD:
        if (hs)         state_nx = DATA_WAIT;
        else if (under) state_nx = FLUSH;
      DATA_WAIT:
        if (bus.piso_done)
          state_nx = (rem != 0) ? DATA_LOAD : FLUSH;
      FLUSH:
        if (stuffer_done) state_nx = EOP_SE0;
      EOP_SE0:
        if (se0_end) state_nx = EOP_J;
      EOP_J:
        if (j_end) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // A SYNC load is launched on the edge that enters SYNC_LOAD,
  // so the strobe is visible for exactly the SYNC_LOAD cycle.
  always_comb begin
    load_sync   = (state_nx == SYNC_LOAD) &&
                  !bus.piso_busy;
    load_nx     = load_sync || hs;
    data_nx     = data_q;
    ready_nx    = (state_nx == DATA_LOAD) &&
                  !bus.piso_busy;
    sync_cnt_nx = sync_idx + SC_W'(load_sync);
    rem_nx      = rem;
    err_nx      = ((state == IDLE) && start_bad) || under;
    done_nx     = (state == EOP_J) && j_end;
    if (hs)
      data_nx = bus.data_in;
    else if (load_sync)
      data_nx = sync_byte(32'(sync_idx), SYNC_BYTES);
    if ((state == IDLE) && start_ok)
      rem_nx = tx_len;
    else if (hs)
      rem_nx = rem - LEN_W'(1);
    else if (under)
      rem_nx = '0;
  end

  usb_eop_gen #(
    .EOP_SE0_BITS(EOP_SE0_BITS)
  ) u_eop (
    .clk     (clk),
    .rst     (rst),
    .start   (eop_start),
    .bit_tick(bit_tick),
    .se0     (line_se0),
    .j       (line_j),
    .se0_end (se0_end),
    .j_end   (j_end)
  );

  assign bus.piso_load  = load_q;
  assign bus.piso_data  = data_q;
  assign bus.data_ready = ready_q;
  assign tx_busy        = (state != IDLE);
  assign tx_done        = done_q;
  assign tx_err         = err_q;

endmodule

// File: doc/usb_tx_framer.md
USB_TX_FRAMER -- requirements
Module: usb_tx_framer

Interface
REQ-001 Parameter SYNC_BYTES, default 1: SYNC length in bytes (1 = full-speed, 4 = high-speed).
REQ-002 Parameter MAX_LEN, default 64: maximum payload bytes per packet; LEN_W = $clog2(MAX_LEN+1).
REQ-003 Parameter EOP_SE0_BITS, default 2: number of SE0 bit times in the EOP, followed by 1 J bit time.
REQ-004 clk  in  1  single clock; all logic is rising-edge triggered.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 tx_start  in  1  one-cycle request to send a packet; honoured only in IDLE.
REQ-007 tx_len  in  LEN_W  payload byte count, sampled with tx_start.
REQ-008 data_valid / data_in[7:0] / data_ready  in/in/out  payload byte stream; a byte transfers when valid and ready are both high in the same cycle.
REQ-009 bit_tick  in  1  one-cycle strobe per USB bit time.
REQ-010 piso_busy, piso_done  in  1 each  serializer status; piso_done is a one-cycle pulse after the last bit shifts out.
REQ-011 piso_load  out  1; piso_data  out  8  serializer load strobe and byte.
REQ-012 stuffer_done  in  1  bit stuffer has flushed all pending bits.
REQ-013 line_se0, line_j  out  1 each  EOP line-state overrides.
REQ-014 tx_busy, tx_done, tx_err  out  1 each  status outputs.

Function
REQ-015 The FSM SHALL have states IDLE, SYNC_LOAD, SYNC_WAIT, DATA_LOAD, DATA_WAIT, FLUSH, EOP_SE0, EOP_J.
REQ-016 IDLE -> SYNC_LOAD on tx_start with 0 <= tx_len <= MAX_LEN; the block SHALL latch tx_len and reset the SYNC byte counter to 0.
REQ-017 A tx_start with tx_len > MAX_LEN SHALL pulse tx_err for 1 cycle and keep the FSM in IDLE.
REQ-018 SYNC_LOAD, when !piso_busy: assert piso_load for exactly 1 cycle with piso_data = SYNC_FILL for the first SYNC_BYTES-1 bytes and SYNC_LAST for the final byte, then go to SYNC_WAIT.
REQ-019 SYNC_WAIT on piso_done: go to SYNC_LOAD if more SYNC bytes remain; else go to DATA_LOAD if remaining length > 0, else to FLUSH.
REQ-020 DATA_LOAD: assert data_ready only when !piso_busy; on handshake, piso_load = 1 and piso_data = data_in in the same cycle, decrement the remaining count, and go to DATA_WAIT.
REQ-021 DATA_WAIT on piso_done: go to DATA_LOAD if the remaining count is nonzero, else to FLUSH.
REQ-022 Underrun: in DATA_LOAD, if data_valid is low on the first !piso_busy cycle after piso_done, the block SHALL pulse tx_err, abandon the remaining bytes, and go to FLUSH. data_ready SHALL remain low thereafter.
REQ-023 FLUSH -> EOP_SE0 when stuffer_done is high.
REQ-024 EOP_SE0: line_se0 = 1; the FSM SHALL count EOP_SE0_BITS bit_ticks, then go to EOP_J.
REQ-025 EOP_J: line_j = 1 until 1 bit_tick; then pulse tx_done for 1 cycle and return to IDLE.
REQ-026 tx_busy SHALL be high in every state except IDLE.
REQ-027 piso_load SHALL never be asserted while piso_busy is high.
REQ-028 tx_start received outside IDLE SHALL be ignored without error.
REQ-029 Outputs piso_load, piso_data, data_ready, line_se0 and line_j SHALL be registered; latency from tx_start to the first piso_load is 1 cycle when the PISO is idle.

Reset
REQ-030 RST SHALL force IDLE, clear all counters, and drive every output to 0 (piso_data = 8'h00) immediately, including mid-packet; no tx_done is produced for an aborted packet.

Structure
REQ-031 Package usb_tx_pkg SHALL hold the state enum tx_framer_state_t, SYNC_FILL = 8'h00, and SYNC_LAST = 8'h80 (LSB-first: seven 0s then one 1).
REQ-032 Sub-module usb_eop_gen SHALL implement the bit_tick-driven SE0/J sequencer (REQ-024, REQ-025).

Verification
REQ-033 FS, tx_len=3, bytes A5/3C/FF always valid, 1-cycle piso_done 8 cycles after each load -> piso_data sequence 80, A5, 3C, FF; 2 SE0 ticks then 1 J tick; one tx_done.
REQ-034 SYNC_BYTES=4, tx_len=0 -> loads 00, 00, 00, 80; FLUSH; EOP; tx_done; data_ready never high.
REQ-035 tx_len=2 with data_valid dropped before byte 2 -> tx_err pulse, EOP still sent, tx_done pulses.
REQ-036 tx_len=MAX_LEN+1 -> tx_err 1 cycle, tx_busy stays 0, no piso_load.
REQ-037 RST asserted in DATA_WAIT -> all outputs 0 in the same cycle; a subsequent tx_start with tx_len=1 completes normally.
